// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer producing
// datapath control strobes, with a memory-wait timeout, a stall hold and a
// retired-instruction counter.
module multicycle_control_unit #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               memReady,
  input  logic               stall,
  output logic               pcWrite,
  output logic               irWrite,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               regWrite,
  output logic               regDst,
  output logic               memToReg,
  output logic               ALUsrc,
  output logic               branch,
  output logic               jump,
  output logic               byteOperations,
  output logic               move,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               illegal,
  output logic               memError,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instrCount
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_SLTI = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_LB   = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_SB   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b100011;
  localparam logic [5:0] OP_BNE  = 6'b100101;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_J    = 6'b111000;

  // Wait counter only has to reach MEM_TIMEOUT-1.
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] op_sel;
  logic       is_r, is_addi, is_ori, is_slti, is_lw, is_lb, is_sw, is_sb;
  logic       is_beq, is_bne, is_move, is_j;
  logic       is_load, is_store, is_branch, is_legal;
  logic [2:0] alu_code;
  logic       tmo_hit;
  logic       retire;

  // DECODE looks at the live opcode; later states use the latched copy.
  assign op_sel    = (state_q == DECODE) ? opcode : op_q;
  assign is_r      = (op_sel == OP_R);
  assign is_addi   = (op_sel == OP_ADDI);
  assign is_ori    = (op_sel == OP_ORI);
  assign is_slti   = (op_sel == OP_SLTI);
  assign is_lw     = (op_sel == OP_LW);
  assign is_lb     = (op_sel == OP_LB);
  assign is_sw     = (op_sel == OP_SW);
  assign is_sb     = (op_sel == OP_SB);
  assign is_beq    = (op_sel == OP_BEQ);
  assign is_bne    = (op_sel == OP_BNE);
  assign is_move   = (op_sel == OP_MOVE);
  assign is_j      = (op_sel == OP_J);
  assign is_load   = is_lw | is_lb;
  assign is_store  = is_sw | is_sb;
  assign is_branch = is_beq | is_bne;
  assign is_legal  = is_r | is_addi | is_ori | is_slti | is_load | is_store |
                     is_branch | is_move | is_j;

  // Timeout fires only while waiting on memory (FETCH or MEM).
  assign tmo_hit = (MEM_TIMEOUT != 0) && !memReady && (tmo_q == TMO_LAST) &&
                   ((state_q == FETCH) || (state_q == MEM));

  // ALU operation code for the instruction being executed.
  always_comb begin
    alu_code = 3'b000;
    if (is_r)                                            alu_code = 3'b111;
    else if (is_addi | is_load | is_store | is_move)     alu_code = 3'b101;
    else if (is_ori)                                     alu_code = 3'b001;
    else if (is_slti)                                    alu_code = 3'b100;
    else if (is_branch)                                  alu_code = 3'b110;
  end

  // Next-state, opcode latch, wait counter and retire counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (memReady)     state_d = DECODE;
        else if (tmo_hit) state_d = FETCH;
      end
      DECODE: begin
        op_d = opcode;
        if (!is_legal) begin
          state_d = FETCH;
        end else if (is_j) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_branch) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (is_load | is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (memReady) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = FETCH;
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    if (stall) begin
      state_d = state_q;
      op_d    = op_q;
    end else begin
      if (retire) cnt_d = cnt_q + CNT_W'(1);
      if (tmo_hit || ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM))))
        tmo_d = '0;
      else if (!memReady)
        tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Registers; reset aborts any in-flight instruction even under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore-style control decode; stall masks every write and fault strobe.
  always_comb begin
    pcWrite        = 1'b0;
    irWrite        = 1'b0;
    iorD           = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    regWrite       = 1'b0;
    regDst         = 1'b0;
    memToReg       = 1'b0;
    ALUsrc         = 1'b0;
    branch         = 1'b0;
    jump           = 1'b0;
    byteOperations = 1'b0;
    move           = 1'b0;
    ALUop          = '0;
    illegal        = 1'b0;
    memError       = 1'b0;
    case (state_q)
      FETCH: begin
        memRead  = 1'b1;
        irWrite  = memReady;
        pcWrite  = memReady;
        memError = tmo_hit;
      end
      DECODE: begin
        illegal = !is_legal;
        jump    = is_j;
        pcWrite = is_j;
      end
      EXEC: begin
        ALUop  = ALUOP_W'(alu_code);
        ALUsrc = !(is_r | is_branch);
        branch = is_branch;
      end
      MEM: begin
        iorD           = 1'b1;
        ALUsrc         = 1'b1;
        memRead        = is_load;
        memWrite       = is_store;
        byteOperations = is_lb | is_sb;
        memError       = tmo_hit;
      end
      WB: begin
        regWrite = 1'b1;
        regDst   = is_r;
        memToReg = is_load;
        move     = is_move;
      end
      default: ;
    endcase
    if (stall) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
      illegal  = 1'b0;
      memError = 1'b0;
    end
  end

  assign state      = state_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver pushes the
// expected per-cycle outputs of an instruction-level reference model; a
// negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_unit;

  localparam int ALUOP_W     = 3;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 6;

  localparam int K_ILL = 0, K_R = 1, K_IMM = 2, K_LOAD = 3, K_STORE = 4,
                 K_BR = 5, K_MOVE = 6, K_J = 7;

  logic clk, reset, memReady, stall;
  logic [5:0] opcode;
  logic pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg;
  logic ALUsrc, branch, jump, byteOperations, move, illegal, memError;
  logic [ALUOP_W-1:0] ALUop;
  logic [2:0] state;
  logic [CNT_W-1:0] instrCount;

  multicycle_control_unit #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady), .stall(stall),
    .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .ALUsrc(ALUsrc), .branch(branch), .jump(jump), .byteOperations(byteOperations),
    .move(move), .ALUop(ALUop), .illegal(illegal), .memError(memError),
    .state(state), .instrCount(instrCount)
  );

  typedef struct packed {
    logic [14:0]      ctl;
    logic [2:0]       alu;
    logic [2:0]       st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: phase 0..4 (fetch, decode, exec, mem, wb).
  int         m_state = 0;
  logic [5:0] m_op    = '0;
  int         m_wait  = 0;
  int         m_cnt   = 0;
  bit         m_valid = 0;

  logic [5:0] legal_ops [12] = '{6'b000000, 6'b000010, 6'b000101, 6'b000111,
                                 6'b001000, 6'b001001, 6'b010000, 6'b010001,
                                 6'b100011, 6'b100101, 6'b100000, 6'b111000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000:                       return K_R;
      6'b000010, 6'b000101, 6'b000111: return K_IMM;
      6'b001000, 6'b001001:            return K_LOAD;
      6'b010000, 6'b010001:            return K_STORE;
      6'b100011, 6'b100101:            return K_BR;
      6'b100000:                       return K_MOVE;
      6'b111000:                       return K_J;
      default:                         return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op);
    case (op)
      6'b000000:                                             return 3'b111;
      6'b000010, 6'b001000, 6'b001001, 6'b010000, 6'b010001,
      6'b100000:                                             return 3'b101;
      6'b000101:                                             return 3'b001;
      6'b000111:                                             return 3'b100;
      6'b100011, 6'b100101:                                  return 3'b110;
      default:                                               return 3'b000;
    endcase
  endfunction

  function automatic bit timed_out(input bit mr);
    return (MEM_TIMEOUT != 0) && !mr && (m_state == 0 || m_state == 3) &&
           (m_wait == MEM_TIMEOUT - 1);
  endfunction

  // Expected outputs for the current cycle given the applied inputs.
  function automatic exp_t model_out(input logic [5:0] op, input bit mr, input bit st);
    exp_t r;
    logic [5:0] cur;
    int k;
    bit pcw, irw, iord, mrd, mwr, rw, rd, m2r, asrc, br, jmp, byt, mv, ill, merr;
    logic [2:0] alu;
    cur = (m_state == 1) ? op : m_op;
    k = kind_of(cur);
    {pcw, irw, iord, mrd, mwr, rw, rd, m2r, asrc, br, jmp, byt, mv, ill, merr} = '0;
    alu = 3'b000;
    case (m_state)
      0: begin mrd = 1; irw = mr; pcw = mr; merr = timed_out(mr); end
      1: begin ill = (k == K_ILL); jmp = (k == K_J); pcw = (k == K_J); end
      2: begin alu = aluop_of(cur); asrc = !(k == K_R || k == K_BR); br = (k == K_BR); end
      3: begin
        iord = 1; asrc = 1; mrd = (k == K_LOAD); mwr = (k == K_STORE);
        byt = (cur == 6'b001001 || cur == 6'b010001); merr = timed_out(mr);
      end
      4: begin rw = 1; rd = (k == K_R); m2r = (k == K_LOAD); mv = (k == K_MOVE); end
      default: ;
    endcase
    if (st) begin pcw = 0; irw = 0; rw = 0; mwr = 0; ill = 0; merr = 0; end
    r.ctl = {pcw, irw, iord, mrd, mwr, rw, rd, m2r, asrc, br, jmp, byt, mv, ill, merr};
    r.alu = alu;
    r.st  = 3'(m_state);
    r.cnt = CNT_W'(m_cnt);
    return r;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_step(input bit rst, input logic [5:0] op, input bit mr, input bit st);
    int nxt, k;
    bit ret, tmo;
    if (rst) begin
      m_state = 0; m_op = '0; m_wait = 0; m_cnt = 0; m_valid = 1;
      return;
    end
    if (!m_valid || st) return;
    tmo = timed_out(mr);
    nxt = m_state;
    ret = 0;
    case (m_state)
      0: if (mr) nxt = 1;
      1: begin
        m_op = op;
        k = kind_of(op);
        if (k == K_ILL) nxt = 0;
        else if (k == K_J) begin nxt = 0; ret = 1; end
        else nxt = 2;
      end
      2: begin
        k = kind_of(m_op);
        if (k == K_BR) begin nxt = 0; ret = 1; end
        else if (k == K_LOAD || k == K_STORE) nxt = 3;
        else nxt = 4;
      end
      3: begin
        k = kind_of(m_op);
        if (mr) begin
          if (k == K_LOAD) nxt = 4;
          else begin nxt = 0; ret = 1; end
        end else if (tmo) nxt = 0;
      end
      default: begin nxt = 0; ret = 1; end
    endcase
    if (ret) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (tmo || (nxt != m_state && (nxt == 0 || nxt == 3))) m_wait = 0;
    else if (!mr) m_wait = m_wait + 1;
    m_state = nxt;
  endtask

  task automatic cycle(input bit rst, input logic [5:0] op, input bit mr, input bit st);
    reset    = rst;
    opcode   = op;
    memReady = mr;
    stall    = st;
    if (m_valid) exp_q.push_back(model_out(op, mr, st));
    @(posedge clk);
    model_step(rst, op, mr, st);
    #1;
  endtask

  // Monitor: one output set is presented per cycle.
  exp_t e;
  logic [14:0] got_ctl;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got_ctl = {pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst,
                 memToReg, ALUsrc, branch, jump, byteOperations, move, illegal, memError};
      total++;
      if ({got_ctl, ALUop, state} !== {e.ctl, e.alu, e.st}) begin
        bad++;
        $display("FAIL outputs cyc=%0d got ctl=%b alu=%b state=%0d want ctl=%b alu=%b state=%0d",
                 cyc, got_ctl, ALUop, state, e.ctl, e.alu, e.st);
      end
      total++;
      if (instrCount !== e.cnt) begin
        bad++;
        $display("FAIL instrCount cyc=%0d got=%0d want=%0d", cyc, instrCount, e.cnt);
      end
      cyc++;
    end
  end

  initial begin
    int drought;
    bit mr, st, rst;
    logic [5:0] op;
    reset = 1'b1; opcode = '0; memReady = 1'b0; stall = 1'b0;
    drought = 0;

    cycle(1, 6'b000000, 0, 0);
    cycle(1, 6'b000000, 0, 0);
    // R-type: fetch, decode, exec, wb
    cycle(0, 6'b000000, 1, 0); repeat (3) cycle(0, 6'b000000, 0, 0);
    // lb with three memory wait cycles
    cycle(0, 6'b001001, 1, 0); cycle(0, 6'b001001, 0, 0); cycle(0, 6'b001001, 0, 0);
    repeat (3) cycle(0, 6'b001001, 0, 0);
    cycle(0, 6'b001001, 1, 0); cycle(0, 6'b001001, 0, 0);
    // sw that never completes: timeout in MEM
    cycle(0, 6'b010000, 1, 0); cycle(0, 6'b010000, 0, 0); cycle(0, 6'b010000, 0, 0);
    repeat (16) cycle(0, 6'b010000, 0, 0);
    // illegal opcode
    cycle(0, 6'b111111, 1, 0); cycle(0, 6'b111111, 0, 0);
    // stall with memReady in FETCH, then release
    cycle(0, 6'b000010, 1, 1); cycle(0, 6'b000010, 1, 1);
    cycle(0, 6'b000010, 1, 0); repeat (3) cycle(0, 6'b000010, 0, 0);
    // jump and branch
    cycle(0, 6'b111000, 1, 0); cycle(0, 6'b111000, 0, 0);
    cycle(0, 6'b100011, 1, 0); cycle(0, 6'b100011, 0, 0); cycle(0, 6'b100011, 0, 0);
    // reset in the middle of an lw memory access
    cycle(0, 6'b001000, 1, 0); cycle(0, 6'b001000, 0, 0); cycle(0, 6'b001000, 0, 0);
    cycle(0, 6'b001000, 0, 0); cycle(1, 6'b001000, 0, 0);
    // FETCH timeout
    repeat (17) cycle(0, 6'b000000, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (drought == 0 && $urandom_range(0, 49) == 0) drought = $urandom_range(10, 20);
      mr = (drought > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (drought > 0) drought--;
      st  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      op  = ($urandom_range(0, 9) != 0) ? legal_ops[$urandom_range(0, 11)] : 6'($urandom);
      cycle(rst, op, mr, st);
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly the three lines below:
REQ-002 ALUOP_W, 3, ALUop width (>=3); codes below zero-extended into upper bits.
REQ-003 MEM_TIMEOUT, 16, max wait cycles for memReady; 0 disables timeout.
REQ-004 CNT_W, 16, width of retired-instruction counter.
REQ-005 Ports (name, direction, width, meaning) SHALL be exactly:
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 opcode  input  6  instruction opcode from IR.
REQ-009 memReady  input  1  memory completes the current access this cycle.
REQ-010 stall  input  1  hold FSM; suppress all write enables.
REQ-011 pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg, ALUsrc, branch, jump, byteOperations, move  output  1 each  datapath controls.
REQ-012 ALUop  output  ALUOP_W  ALU operation code.
REQ-013 illegal, memError  output  1 each  one-cycle fault pulses.
REQ-014 state  output  3  current state code; instrCount  output  CNT_W  retired instructions.

Function
REQ-015 Opcodes: R 000000, addi 000010, ori 000101, slti 000111, lw 001000, lb 001001, sw 010000, sb 010001, beq 100011, bne 100101, move 100000, j 111000; any other opcode is illegal.
REQ-016 ALUop: R 111, addi/lw/lb/sw/sb/move 101, ori 001, slti 100, beq/bne 110, otherwise 000.
REQ-017 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unreachable and SHALL go to FETCH.
REQ-018 Outputs are Moore: decoded from state and opReg, a 6-bit register loaded from opcode on leaving DECODE; in DECODE, decode uses opcode directly.
REQ-019 Every output not asserted by the rules below SHALL be 0.
REQ-020 FETCH: memRead=1, iorD=0; irWrite=pcWrite=memReady; on memReady -> DECODE.
REQ-021 DECODE: illegal -> illegal=1, -> FETCH; j -> jump=1, pcWrite=1, -> FETCH; else -> EXEC.
REQ-022 EXEC: ALUop per opcode; ALUsrc=1 except R/beq/bne; branch=1 for beq/bne; beq/bne -> FETCH; lw/lb/sw/sb -> MEM; others -> WB.
REQ-023 MEM: iorD=1, ALUsrc=1; memRead=1 for loads, memWrite=1 for stores; byteOperations=1 for lb/sb; on memReady loads -> WB, stores -> FETCH; else stay.
REQ-024 WB: regWrite=1; regDst=1 for R only; memToReg=1 for lw/lb; move=1 for move; -> FETCH.
REQ-025 Timeout: counter clears on entering FETCH or MEM, increments each un-stalled cycle without memReady; when it equals MEM_TIMEOUT-1 with no memReady, memError=1 that cycle and next state FETCH (counter cleared).
REQ-026 Stall: while stall=1, state, opReg, counter and instrCount hold; pcWrite, irWrite, regWrite, memWrite, illegal, memError forced 0; stall wins over simultaneous memReady.
REQ-027 instrCount increments by 1 on each transition into FETCH from DECODE (j), EXEC, MEM or WB; not on illegal or memError; wraps 2^CNT_W-1 -> 0.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=FETCH, opReg=0, counter=0, instrCount=0, aborting any in-flight instruction, regardless of stall.
REQ-029 Outputs the cycle after reset: memRead=1, state=0, all others 0 (irWrite/pcWrite then follow memReady).

Verification
REQ-030 R-type, memReady=1 in FETCH -> states 0,1,2,4,0; regWrite=regDst=1 in WB only; ALUop=111 in EXEC; instrCount 0->1.
REQ-031 lb, memReady low 3 cycles in MEM -> MEM held 4 cycles, memRead=byteOperations=iorD=1 throughout; WB memToReg=1.
REQ-032 sw with memReady never high, MEM_TIMEOUT=16 -> memError pulse on 16th MEM cycle, state 0 next, instrCount unchanged.
REQ-033 opcode 111111 in DECODE -> illegal=1 for one cycle, FETCH next, no write enable asserted.
REQ-034 stall=1 with memReady=1 in FETCH for 2 cycles -> state stays 0, irWrite=pcWrite=0; stall drop -> DECODE next edge.
REQ-035 reset asserted mid-MEM of lw -> next cycle state=0, instrCount=0, memWrite=regWrite=0.
